// File: rtl/secded_pkg.sv
// Shared types and constant helpers for the SECDED (extended Hamming) decoder.
package secded_pkg;

    typedef enum logic [1:0] {
        NO_ERR  = 2'b00,
        SGL_ERR = 2'b01,
        DBL_ERR = 2'b10
    } flag_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_LAST,
        S_DEC,
        S_WR,
        S_DONE
    } state_e;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int par_width(int data_w);
        int r;
        r = 0;
        while ((1 << r) < (data_w + r + 1)) r++;
        return r;
    endfunction

    // Hamming parity bits plus the overall parity bit at position 0.
    function automatic int cw_width(int data_w);
        return data_w + par_width(data_w) + 1;
    endfunction

    function automatic bit is_pow2(int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

endpackage

// File: rtl/secded_core.sv
// Combinational SECDED decode of one codeword into {flag, corrected data}.
module secded_core
    import secded_pkg::*;
#(
    parameter int DATA_W = 11
) (
    input  logic [cw_width(DATA_W)-1:0] cw,
    output flag_e                       flag,
    output logic [DATA_W-1:0]           data
);

    localparam int CW = cw_width(DATA_W);
    localparam int SW = par_width(DATA_W);

    // Position of data bit j: the j-th non-power-of-two position above 0.
    function automatic int data_pos(int j);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p < CW; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [SW-1:0] syn;
    logic          par;
    logic [CW-1:0] fixed;

    always_comb begin
        syn   = '0;
        par   = cw[0];
        fixed = cw;
        flag  = NO_ERR;
        for (int i = 1; i < CW; i++) begin
            if (cw[i]) syn = syn ^ SW'(i);
            par = par ^ cw[i];
        end
        // Odd parity means a single error at position syn (syn=0 is p0 itself).
        if (par) begin
            flag       = SGL_ERR;
            fixed[syn] = ~fixed[syn];
        end else if (syn != '0) begin
            flag = DBL_ERR;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign data[j] = fixed[data_pos(j)];
    end

endmodule

// File: rtl/secded_mem_decoder.sv
// Memory-mapped SECDED batch decoder: reads NUM_MSG codewords, writes flagged results.
// Optional error counters enabled by defining SECDED_ERR_STATS_EN.
module secded_mem_decoder
    import secded_pkg::*;
#(
    parameter int DATA_W   = 11,
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata
`ifdef SECDED_ERR_STATS_EN
    ,
    output logic [7:0]        err_single_cnt,
    output logic [7:0]        err_double_cnt
`endif
);

    localparam int CW  = cw_width(DATA_W);
    localparam int B   = CW / 8;
    localparam int MW  = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam int BCW = 3;

    state_e            state_q, state_d;
    logic [MW-1:0]     msg_q, msg_d;
    logic [BCW-1:0]    byte_q, byte_d;
    logic [CW-1:0]     cw_q, cw_d;
    logic [CW-1:0]     res_q, res_d;
    logic [CW-1:0]     res_shift;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wdata_q, wdata_d;

    flag_e             core_flag;
    logic [DATA_W-1:0] core_data;

    secded_core #(.DATA_W(DATA_W)) u_core (
        .cw   (cw_q),
        .flag (core_flag),
        .data (core_data)
    );

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        byte_d  = byte_q;
        cw_d    = cw_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RD;
                    msg_d   = '0;
                    byte_d  = '0;
                end
            end
            S_RD: begin
                // Bytes arrive one cycle after their strobe and shift in from the top.
                if (byte_q != '0) cw_d = (cw_q >> 8) | (CW'(mem_rdata) << (CW - 8));
                if (byte_q == BCW'(B - 1)) state_d = S_RD_LAST;
                else                       byte_d  = byte_q + BCW'(1);
            end
            S_RD_LAST: begin
                cw_d    = (cw_q >> 8) | (CW'(mem_rdata) << (CW - 8));
                state_d = S_DEC;
            end
            S_DEC: begin
                res_d                 = '0;
                res_d[DATA_W-1:0]     = core_data;
                res_d[CW-1 -: 2]      = core_flag;
                byte_d                = '0;
                state_d               = S_WR;
            end
            S_WR: begin
                if (byte_q == BCW'(B - 1)) begin
                    byte_d = '0;
                    if (msg_q == MW'(NUM_MSG - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        msg_d   = msg_q + MW'(1);
                        state_d = S_RD;
                    end
                end else begin
                    byte_d = byte_q + BCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Memory strobes are registered so they line up with the state they belong to.
        rd_en_d   = (state_d == S_RD);
        wr_en_d   = (state_d == S_WR);
        res_shift = res_d >> (8 * int'(byte_d));
        addr_d    = '0;
        wdata_d   = '0;
        if (rd_en_d) addr_d = ADDR_W'(SRC_BASE + B * int'(msg_d) + int'(byte_d));
        if (wr_en_d) begin
            addr_d  = ADDR_W'(DST_BASE + B * int'(msg_d) + int'(byte_d));
            wdata_d = res_shift[7:0];
        end
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        cw_q  <= cw_d;
        res_q <= res_d;
    end

    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_wdata = wdata_q;

`ifdef SECDED_ERR_STATS_EN
    logic [7:0] sgl_q, sgl_d;
    logic [7:0] dbl_q, dbl_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        sgl_d = sgl_q;
        dbl_d = dbl_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            sgl_d = '0;
            dbl_d = '0;
        end else if (state_q == S_DEC) begin
            if (core_flag == SGL_ERR) sgl_d = sat_inc(sgl_q);
            if (core_flag == DBL_ERR) dbl_d = sat_inc(dbl_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sgl_q <= '0;
            dbl_q <= '0;
        end else begin
            sgl_q <= sgl_d;
            dbl_q <= dbl_d;
        end
    end

    assign err_single_cnt = sgl_q;
    assign err_double_cnt = dbl_q;
`endif

endmodule

// File: tb/tb_secded_mem_decoder.sv
// Scoreboard bench for secded_mem_decoder with a byte-wide synchronous memory model.
module tb_secded_mem_decoder;

    localparam int DATA_W = 11;
    localparam int NMSG   = 15;
    localparam int SRC    = 30;
    localparam int DST    = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
`ifdef SECDED_ERR_STATS_EN
    logic [7:0] err_single_cnt;
    logic [7:0] err_double_cnt;
`endif

    logic [7:0] mem [256];
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    logic [15:0] sb [$];
    logic [15:0] cw_arr  [NMSG];
    logic [15:0] exp_arr [NMSG];
    int          n_sgl;
    int          n_dbl;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    secded_mem_decoder #(
        .DATA_W(DATA_W), .NUM_MSG(NMSG), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
`ifdef SECDED_ERR_STATS_EN
        ,
        .err_single_cnt (err_single_cnt),
        .err_double_cnt (err_double_cnt)
`endif
    );

    always @(posedge clk) begin
        if (ld_en)          mem[ld_addr]  <= ld_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en)      mem_rdata     <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference encoder: data at non-power-of-two positions, parity bit 2^b covers positions with bit b set.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic        x;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int p = 1; p < 16; p++) if (((p >> b) & 1) == 1) x = x ^ c[p];
            c[1 << b] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p];
                k++;
            end
        end
        return d;
    endfunction

    // Expected results follow from the injected fault, not from a syndrome computation.
    task automatic gen_batch(input bit directed);
        logic [10:0] d;
        logic [15:0] c;
        logic [15:0] e;
        int          kind;
        int          a;
        int          b2;
        n_sgl = 0;
        n_dbl = 0;
        for (int m = 0; m < NMSG; m++) begin
            if (directed && m < 4) begin
                case (m)
                    0:       begin c = 16'hFFFF; e = 16'h07FF; end
                    1:       begin c = 16'h0020; e = 16'h4000; n_sgl++; end
                    2:       begin c = 16'h0001; e = 16'h4000; n_sgl++; end
                    default: begin c = 16'h0220; e = 16'h8012; n_dbl++; end
                endcase
            end else begin
                d    = 11'($urandom);
                c    = encode(d);
                kind = int'($urandom_range(0, 3));
                a    = int'($urandom_range(0, 15));
                case (kind)
                    1: begin
                        c[a] = ~c[a];
                        e    = {2'b01, 3'b000, d};
                        n_sgl++;
                    end
                    2: begin
                        b2    = (a + 1 + int'($urandom_range(0, 14))) % 16;
                        c[a]  = ~c[a];
                        c[b2] = ~c[b2];
                        e     = {2'b10, 3'b000, extract(c)};
                        n_dbl++;
                    end
                    3: begin
                        c[a] = ~c[a];
                        c[a] = ~c[a];
                        e    = {2'b00, 3'b000, d};
                    end
                    default: e = {2'b00, 3'b000, d};
                endcase
            end
            cw_arr[m]  = c;
            exp_arr[m] = e;
        end
    endtask

    task automatic load_mem();
        for (int m = 0; m < NMSG; m++) begin
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                ld_en   = 1'b1;
                ld_addr = 8'(SRC + 2 * m + b);
                ld_data = cw_arr[m][8*b +: 8];
            end
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_expected();
        for (int m = 0; m < NMSG; m++) begin
            sb.push_back({8'(DST + 2 * m),     exp_arr[m][7:0]});
            sb.push_back({8'(DST + 2 * m + 1), exp_arr[m][15:8]});
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_drop", 32'(done), 32'd0);
    endtask

    task automatic run_batch(input bit poke_busy);
        int cyc;
        cyc = 0;
        do_start();
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (poke_busy && k == 20) start = 1'b1;
            if (done) begin
                cyc = k;
                break;
            end
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_cycle", 32'(cyc), 32'd91);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 32'(done), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef SECDED_ERR_STATS_EN
        check("err_single_cnt", 32'(err_single_cnt), 32'(n_sgl));
        check("err_double_cnt", 32'(err_double_cnt), 32'(n_dbl));
`endif
    endtask

    always @(negedge clk) begin
        if (!reset && mem_wr_en) begin
            check("rd_wr_excl", 32'(mem_rd_en), 32'd0);
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else                check("wr_byte", 32'({mem_addr, mem_wdata}), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done",  32'(done),      32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors first, then random faults; a start is poked mid-batch.
        gen_batch(1'b1);
        load_mem();
        push_expected();
        run_batch(1'b1);

        // Abort during the first write of message 7, then reprocess from scratch.
        gen_batch(1'b0);
        load_mem();
        push_expected();
        do_start();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (mem_wr_en && mem_addr == 8'(DST + 14)) break;
        end
        check("wr7_seen", 32'(mem_wr_en), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_done",  32'(done),      32'd0);
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_addr",  32'(mem_addr),  32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_rd_en", 32'(mem_rd_en), 32'd0);
        push_expected();
        run_batch(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
